// File: rtl/fcs_checker_pkg.sv
// Ethernet FCS constants and status encoding shared with the trash controller.
package fcs_checker_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;
    localparam int          ETH_MIN_FRAME   = 64;

    typedef enum logic [1:0] {
        FCS_IDLE = 2'b00,
        FCS_GOOD = 2'b10,
        FCS_BAD  = 2'b11
    } fcs_status_t;

    typedef enum logic {
        ST_IDLE,
        ST_IN_FRAME
    } fcs_state_t;

endpackage

// File: rtl/fcs_checker_if.sv
// Receive byte stream into the FCS checker (preamble/SFD already stripped).
interface fcs_checker_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sof;
    logic       rx_eof;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_sof,
        output rx_eof
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input rx_sof,
        input rx_eof
    );

endinterface

// File: rtl/fcs_checker_crc32.sv
// One-byte step of the reflected CRC-32, fully unrolled, purely combinational.
module crc32_byte_next
    import fcs_checker_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY_REFL;
            else                c = c >> 1;
        end
        crc_out = c;
    end

endmodule

// File: rtl/fcs_checker.sv
// Ethernet FCS checker: one {valid,error} pulse plus length per frame.
// Define FCS_CHECKER_RUNT_CHECK_EN to also flag frames shorter than 64 bytes.
module fcs_checker
    import fcs_checker_pkg::*;
#(
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    fcs_checker_if.slave     rx,
    output logic [1:0]       fcs_error,
    output logic [LEN_W-1:0] frame_len,
    output logic             busy
);

    localparam logic [LEN_W-1:0] CNT_MAX = '1;

    fcs_state_t        state_q, state_d;
    logic [31:0]       crc_q, crc_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    fcs_status_t       stat_q, stat_d;
    logic [LEN_W-1:0]  len_q, len_d;

    logic              sof_v, eof_v;
    logic [31:0]       crc_seed, crc_nxt;
    logic [LEN_W-1:0]  cnt_nxt;
    logic              crc_bad, runt;

    assign sof_v    = rx.rx_valid & rx.rx_sof;
    assign eof_v    = rx.rx_valid & rx.rx_eof;
    assign crc_seed = sof_v ? CRC32_INIT : crc_q;

    crc32_byte_next u_crc (
        .crc_in  (crc_seed),
        .data    (rx.rx_data),
        .crc_out (crc_nxt)
    );

    // A sof byte always restarts the count, even when it aborts a frame.
    always_comb begin
        cnt_nxt = cnt_q;
        if (sof_v)                cnt_nxt = LEN_W'(1);
        else if (cnt_q != CNT_MAX) cnt_nxt = cnt_q + LEN_W'(1);
    end

    assign crc_bad = (crc_nxt != CRC32_RESIDUE);

`ifdef FCS_CHECKER_RUNT_CHECK_EN
    assign runt = (int'(cnt_nxt) < ETH_MIN_FRAME);
`else
    assign runt = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        stat_d  = FCS_IDLE;
        len_d   = len_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sof_v) begin
                    crc_d = crc_nxt;
                    cnt_d = cnt_nxt;
                    if (eof_v) begin
                        stat_d = FCS_BAD;
                        len_d  = cnt_nxt;
                    end else begin
                        state_d = ST_IN_FRAME;
                    end
                end
            end
            ST_IN_FRAME: begin
                if (rx.rx_valid) begin
                    crc_d = crc_nxt;
                    cnt_d = cnt_nxt;
                    unique case (1'b1)
                        sof_v & eof_v: begin
                            stat_d  = FCS_BAD;
                            len_d   = cnt_nxt;
                            state_d = ST_IDLE;
                        end
                        sof_v & ~eof_v: begin
                            stat_d = FCS_BAD;
                            len_d  = cnt_q;
                        end
                        ~sof_v & eof_v: begin
                            stat_d  = (crc_bad | runt) ? FCS_BAD : FCS_GOOD;
                            len_d   = cnt_nxt;
                            state_d = ST_IDLE;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            crc_q   <= CRC32_INIT;
            cnt_q   <= '0;
            stat_q  <= FCS_IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            stat_q  <= stat_d;
            len_q   <= len_d;
        end
    end

    assign fcs_error = stat_q;
    assign frame_len = len_q;
    assign busy      = (state_q == ST_IN_FRAME);

endmodule

// File: tb/tb_fcs_checker.sv
// Randomised bench for fcs_checker against a frame-level reference model.
module tb_fcs_checker;
    import fcs_checker_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  fcs_error;
    logic [10:0] frame_len;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fcs_checker_if rx_if ();

    fcs_checker #(.LEN_W(11)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx_if),
        .fcs_error (fcs_error),
        .frame_len (frame_len),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Textbook CRC-32 (with final inversion) over a byte list.
    function automatic logic [31:0] crc32(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Good frame: trailing 4 bytes equal CRC of the rest, LSB first.
    function automatic bit frame_ok(input logic [7:0] q[$]);
        logic [7:0]  pl[$];
        logic [31:0] fcs;
        int n;
        n = q.size();
        if (n < 5) return 1'b0;
        for (int i = 0; i < n - 4; i++) pl.push_back(q[i]);
        fcs = {q[n-1], q[n-2], q[n-3], q[n-4]};
        return crc32(pl) == fcs;
    endfunction

    function automatic int sat(input int n);
        return (n > 2047) ? 2047 : n;
    endfunction

    // Reference model: updated on each posedge, checked on the next negedge.
    logic [7:0] mq[$];
    bit         m_in = 1'b0;
    bit         started = 1'b0;
    logic [1:0] e_err = 2'b00;
    int         e_len = 0;
    bit         e_len_chk = 1'b0;

    always @(posedge clk) begin
        bit bad;
        started   = 1'b1;
        e_err     = 2'b00;
        e_len_chk = 1'b0;
        if (!reset_n) begin
            m_in = 1'b0;
            mq.delete();
            e_len = 0;
            e_len_chk = 1'b1;
        end else if (rx_if.rx_valid) begin
            if (rx_if.rx_sof) begin
                if (m_in) begin
                    e_err = 2'b11;
                    e_len = sat(mq.size());
                    e_len_chk = 1'b1;
                end
                mq.delete();
                mq.push_back(rx_if.rx_data);
                m_in = 1'b1;
            end else if (m_in) begin
                mq.push_back(rx_if.rx_data);
            end
            if (rx_if.rx_eof && m_in) begin
                bad = (mq.size() == 1) || !frame_ok(mq);
`ifdef FCS_CHECKER_RUNT_CHECK_EN
                if (mq.size() < 64) bad = 1'b1;
`endif
                e_err = {1'b1, bad};
                e_len = sat(mq.size());
                e_len_chk = 1'b1;
                m_in = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("fcs_error", {30'h0, fcs_error}, {30'h0, e_err});
            chk("busy", {31'h0, busy}, {31'h0, m_in});
            if (e_len_chk)
                chk("frame_len", {21'h0, frame_len}, e_len);
        end
    end

    task automatic put(input logic v, input logic [7:0] d,
                       input logic s, input logic e);
        @(negedge clk);
        rx_if.rx_valid = v;
        rx_if.rx_data  = d;
        rx_if.rx_sof   = s;
        rx_if.rx_eof   = e;
    endtask

    task automatic stall();
        put(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic send(input logic [7:0] f[$], input int stall_pct);
        for (int i = 0; i < f.size(); i++) begin
            while (int'($urandom_range(99)) < stall_pct) stall();
            put(1'b1, f[i], i == 0, i == f.size() - 1);
        end
    endtask

    function automatic void mk(input int n_pl, output logic [7:0] f[$]);
        logic [31:0] c;
        f.delete();
        for (int i = 0; i < n_pl; i++) f.push_back(8'($urandom));
        c = crc32(f);
        for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    endfunction

    // Check the report visible right after the last driven byte.
    task automatic lit(input string name, input logic [1:0] err,
                       input int len);
        put(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        chk({name, "_err"}, {30'h0, fcs_error}, {30'h0, err});
        chk({name, "_len"}, {21'h0, frame_len}, len);
    endtask

    initial begin
        logic [7:0] f[$];
        logic [7:0] g[$];
        logic [7:0] s9[$];
        string      str;

        reset_n = 1'b0;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        rx_if.rx_sof   = 1'b0;
        rx_if.rx_eof   = 1'b0;
        put(1'b0, 8'h00, 1'b0, 1'b0);
        put(1'b0, 8'h00, 1'b0, 1'b0);
        reset_n = 1'b1;

        str = "123456789";
        for (int i = 0; i < str.len(); i++) s9.push_back(8'(str[i]));
        chk("crc_check_value", crc32(s9), 32'hCBF4_3926);

        f = s9;
        f.push_back(8'h26); f.push_back(8'h39);
        f.push_back(8'hF4); f.push_back(8'hCB);
        send(f, 0);
        lit("t1_good13", 2'b10, 13);

        f[2][0] = ~f[2][0];
        send(f, 0);
        lit("t2_flip13", 2'b11, 13);

        mk(60, f);
        send(f, 0);
        lit("t3_len64", 2'b10, 64);
        mk(56, f);
        send(f, 0);
`ifdef FCS_CHECKER_RUNT_CHECK_EN
        lit("t3_len60", 2'b11, 60);
`else
        lit("t3_len60", 2'b10, 60);
`endif

        mk(60, f);
        mk(60, g);
        for (int i = 0; i < 19; i++) put(1'b1, f[i], i == 0, 1'b0);
        put(1'b1, g[0], 1'b1, 1'b0);
        put(1'b1, g[1], 1'b0, 1'b0);
        #1;
        chk("t4_abort_err", {30'h0, fcs_error}, 32'h3);
        chk("t4_abort_len", {21'h0, frame_len}, 19);
        for (int i = 2; i < 64; i++) put(1'b1, g[i], 1'b0, i == 63);
        lit("t4_after", 2'b10, 64);

        mk(60, f);
        for (int i = 0; i < 29; i++) put(1'b1, f[i], i == 0, 1'b0);
        put(1'b1, f[29], 1'b0, 1'b0);
        reset_n = 1'b0;
        for (int i = 30; i < 64; i++) begin
            put(1'b1, f[i], 1'b0, i == 63);
            reset_n = 1'b1;
        end
        put(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        chk("t5_busy", {31'h0, busy}, 32'h0);
        chk("t5_nopulse", {30'h0, fcs_error}, 32'h0);
        mk(60, f);
        send(f, 0);
        lit("t5_next", 2'b10, 64);

        mk(60, f);
        send(f, 30);
        lit("t6_stall", 2'b10, 64);
        mk(60, f); send(f, 0);
        mk(70, g); send(g, 0);
        mk(3, f);  send(f, 0);
        lit("t6_b2b", 2'b10, 7);

        mk(2096, f);
        send(f, 0);
        lit("sat_len", 2'b10, 2047);

        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = int'($urandom_range(9));
            mk(int'($urandom_range(1, 150)), f);
            if (kind == 0) begin
                put(1'b1, 8'($urandom), 1'b1, 1'b1);
            end else if (kind == 1) begin
                int cut;
                cut = int'($urandom_range(1, f.size() - 2));
                for (int i = 0; i < cut; i++)
                    put(1'b1, f[i], i == 0, 1'b0);
            end else begin
                if (kind < 4) begin
                    int b;
                    b = int'($urandom_range(f.size() - 1));
                    f[b] = f[b] ^ 8'(1 << $urandom_range(7));
                end
                send(f, int'($urandom_range(40)));
            end
            repeat (int'($urandom_range(2))) stall();
        end
        repeat (3) put(1'b0, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
